// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM between NUM_REQ
// requesters. Accepted commands are registered, then issued to the RAM.
// Reads return a one-cycle resp_valid pulse to the granted requester.
module bram_rr_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 256,
    localparam int ADDR_W   = $clog2(RAM_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*RAM_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [RAM_WIDTH-1:0]         resp_rdata,
    output logic                         ram_we,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [RAM_WIDTH-1:0]         ram_din,
    input  logic [RAM_WIDTH-1:0]         ram_dout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_grant;
    logic                  r_cmd_we;
    logic [ADDR_W-1:0]     r_cmd_addr;
    logic [RAM_WIDTH-1:0]  r_cmd_wdata;

    logic                  w_found;
    logic [IDX_W-1:0]      w_winner;
    logic                  w_accept;

    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
        return IDX_W'(v % NUM_REQ);
    endfunction

    // Round-robin search: first valid requester starting at ptr+1.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req_valid[wrap_idx(int'(r_ptr) + k)]) begin
                w_found  = 1'b1;
                w_winner = wrap_idx(int'(r_ptr) + k);
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_found;

    // Next-state logic for the access sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = r_cmd_we ? S_IDLE : S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Capture the winning command and advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_grant     <= '0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else if (w_accept) begin
            r_ptr       <= w_winner;
            r_grant     <= w_winner;
            r_cmd_we    <= req_we[w_winner];
            r_cmd_addr  <= req_addr[w_winner*ADDR_W +: ADDR_W];
            r_cmd_wdata <= req_wdata[w_winner*RAM_WIDTH +: RAM_WIDTH];
        end
    end

    // One-hot accept, suppressed while reset is held.
    always_comb begin
        req_ready = '0;
        if (w_accept && !rst) req_ready[w_winner] = 1'b1;
    end

    // One-cycle read response to the granted requester.
    always_comb begin
        resp_valid = '0;
        if (r_state == S_RESP) resp_valid[r_grant] = 1'b1;
    end

    // The command register holds between accepts, so the RAM address and
    // data naturally keep their last value outside the issue cycle.
    assign ram_we     = (r_state == S_ISSUE) && r_cmd_we;
    assign ram_addr   = r_cmd_addr;
    assign ram_din    = r_cmd_wdata;
    assign resp_rdata = ram_dout;

endmodule
